jtexterm_irqctl: RTL and testbench

JTEXTERM_IRQCTL -- requirements
Module: jtexterm_irqctl

---
 rtl/jtexterm_irqctl_if.sv | 25 ++
 rtl/jtexterm_irqctl.sv | 144 ++++++++++++++
 tb/tb_jtexterm_irqctl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtexterm_irqctl_if.sv
// jtexterm_irqctl_if -- CPU/interrupt-source bus bundle for jtexterm_irqctl.
// slave : the interrupt controller; master : the CPU/source side.
interface jtexterm_irqctl_if #(
  parameter int CH = 2
);
  logic [CH-1:0] irq_src;
  logic          mask_we;
  logic [7:0]    cpu_dout;
  logic          m1_n;
  logic          iorq_n;
  logic          int_n;
  logic          nmi_n;
  logic [7:0]    vector;
  logic [CH-1:0] pending;

  modport slave (
    input  irq_src, mask_we, cpu_dout, m1_n, iorq_n,
    output int_n, nmi_n, vector, pending
  );

  modport master (
    output irq_src, mask_we, cpu_dout, m1_n, iorq_n,
    input  int_n, nmi_n, vector, pending
  );
endinterface

// File: rtl/jtexterm_irqctl.sv
// jtexterm_irqctl -- Z80 interrupt controller: edge-triggered sources,
// maskable pending flags, lowest-index priority, vectored acknowledge.
// Optional macro JTEXTERM_IRQ_NMI_EN: channel 0 becomes a 4-clk NMI pulse
// source and is removed from int_n/priority.
module jtexterm_irqctl #(
  parameter int         CH    = 2,
  parameter logic [7:0] VBASE = 8'h00,
  parameter int         ACKM1 = 1
) (
  input  logic             clk,
  input  logic             rst,
  jtexterm_irqctl_if.slave io
);

  localparam int unsigned NCH = CH;

  logic [CH-1:0] src_l_q, src_l_d;
  logic [CH-1:0] pending_q, pending_d;
  logic [CH-1:0] mask_q, mask_d;
  logic [CH-1:0] rise, elig, clr;
  logic          ack, ack_start;
  logic          ack_l_q, ack_l_d;
  logic          int_n_q, int_n_d;
  logic [7:0]    vector_q, vector_d;
  logic [2:0]    ack_ch_q, ack_ch_d;
  logic [2:0]    sel;
  logic          hit;

`ifdef JTEXTERM_IRQ_NMI_EN
  localparam logic [CH-1:0] NMI_CH = CH'(1);
  logic       nmi_fire;
  logic [2:0] nmi_cnt_q, nmi_cnt_d;
  logic       nmi_n_q, nmi_n_d;
`endif

  // Bits of cpu_dout above the channel count carry no mask information.
  if (CH < 8) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^io.cpu_dout[7:CH];
  end

  // Edge detect, eligibility and acknowledge decode.
  always_comb begin
    rise      = io.irq_src & ~src_l_q;
    src_l_d   = io.irq_src;
    ack       = (ACKM1 != 0) ? (!io.m1_n && !io.iorq_n) : !io.iorq_n;
    ack_start = ack & ~ack_l_q;
    ack_l_d   = ack;
`ifdef JTEXTERM_IRQ_NMI_EN
    elig      = pending_q & mask_q & ~NMI_CH;
`else
    elig      = pending_q & mask_q;
`endif
  end

  // Priority encoder: lowest eligible channel index wins.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!hit && elig[i]) begin
        sel = 3'(i);
        hit = 1'b1;
      end
    end
  end

`ifdef JTEXTERM_IRQ_NMI_EN
  // NMI pulse counter: load 4 on a masked channel-0 rise, count down to idle.
  always_comb begin
    nmi_fire  = rise[0] & mask_q[0];
    nmi_cnt_d = nmi_cnt_q;
    if (nmi_fire)
      nmi_cnt_d = 3'd4;
    else if (nmi_cnt_q != 3'd0)
      nmi_cnt_d = nmi_cnt_q - 3'd1;
    nmi_n_d = (nmi_cnt_d == 3'd0);
  end

  // NMI counter and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_cnt_q <= '0;
      nmi_n_q   <= 1'b1;
    end else begin
      nmi_cnt_q <= nmi_cnt_d;
      nmi_n_q   <= nmi_n_d;
    end
  end

  assign io.nmi_n = nmi_n_q;
`else
  assign io.nmi_n = 1'b1;
`endif

  // Pending/mask/vector next state; a new rise beats a same-edge clear.
  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ack_start && hit && (sel == 3'(i)))
        clr[i] = 1'b1;
    end
`ifdef JTEXTERM_IRQ_NMI_EN
    if (nmi_cnt_q == 3'd1)
      clr[0] = 1'b1;
`endif
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = io.mask_we ? io.cpu_dout[CH-1:0] : mask_q;
    int_n_d   = ~|elig;
    ack_ch_d  = ack_start ? sel : ack_ch_q;
    // The vector tracks the live selection except while an acknowledge
    // that already started is held; then it replays the latched channel.
    if (ack && !ack_start)
      vector_d = VBASE + {4'b0000, ack_ch_q, 1'b0};
    else
      vector_d = VBASE + {4'b0000, sel, 1'b0};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_l_q   <= io.irq_src;
      pending_q <= '0;
      mask_q    <= '1;
      ack_l_q   <= 1'b0;
      int_n_q   <= 1'b1;
      vector_q  <= VBASE;
      ack_ch_q  <= '0;
    end else begin
      src_l_q   <= src_l_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ack_l_q   <= ack_l_d;
      int_n_q   <= int_n_d;
      vector_q  <= vector_d;
      ack_ch_q  <= ack_ch_d;
    end
  end

  assign io.pending = pending_q;
  assign io.int_n   = int_n_q;
  assign io.vector  = vector_q;

endmodule

// File: tb/tb_jtexterm_irqctl.sv
// tb_jtexterm_irqctl -- directed bench for jtexterm_irqctl.
// dut_a: CH=2, VBASE=00, ACKM1=1.  dut_b: CH=3, VBASE=40, ACKM1=0.
module tb_jtexterm_irqctl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  jtexterm_irqctl_if #(.CH(2)) ia ();
  jtexterm_irqctl_if #(.CH(3)) ib ();

  jtexterm_irqctl #(.CH(2), .VBASE(8'h00), .ACKM1(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .io  (ia)
  );

  jtexterm_irqctl #(.CH(3), .VBASE(8'h40), .ACKM1(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .io  (ib)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_a(input logic on);
    ia.m1_n   = ~on;
    ia.iorq_n = ~on;
  endtask

  initial begin
    rst         = 1'b1;
    ia.irq_src  = 2'b10;
    ia.mask_we  = 1'b0;
    ia.cpu_dout = 8'h00;
    ia.m1_n     = 1'b1;
    ia.iorq_n   = 1'b1;
    ib.irq_src  = 3'b000;
    ib.mask_we  = 1'b0;
    ib.cpu_dout = 8'h00;
    ib.m1_n     = 1'b1;
    ib.iorq_n   = 1'b1;
    tick();
    tick();
    check_eq("rst_pend_a", 32'(ia.pending), 32'h0);
    check_eq("rst_int_a",  32'(ia.int_n),   32'h1);
    check_eq("rst_nmi_a",  32'(ia.nmi_n),   32'h1);
    check_eq("rst_vec_a",  32'(ia.vector),  32'h00);
    check_eq("rst_vec_b",  32'(ib.vector),  32'h40);
    check_eq("rst_pend_b", 32'(ib.pending), 32'h0);
    rst = 1'b0;
    tick();
    check_eq("no_rise_after_rst", 32'(ia.pending), 32'h0);
    tick();
    check_eq("int_idle", 32'(ia.int_n), 32'h1);

`ifdef JTEXTERM_IRQ_NMI_EN
    ia.irq_src = 2'b00; tick();
    ia.irq_src = 2'b01; tick();
    check_eq("nmi_low_0",  32'(ia.nmi_n),   32'h0);
    check_eq("nmi_pend",   32'(ia.pending), 32'h1);
    check_eq("nmi_int_0",  32'(ia.int_n),   32'h1);
    for (int k = 1; k < 4; k++) begin
      tick();
      check_eq("nmi_low_k", 32'(ia.nmi_n), 32'h0);
      check_eq("nmi_int_k", 32'(ia.int_n), 32'h1);
    end
    tick();
    check_eq("nmi_end",      32'(ia.nmi_n),   32'h1);
    check_eq("nmi_pend_clr", 32'(ia.pending), 32'h0);
    check_eq("nmi_int_end",  32'(ia.int_n),   32'h1);
    ia.irq_src = 2'b11; tick();
    check_eq("nmi_ch1_pend", 32'(ia.pending), 32'h2);
    tick();
    check_eq("nmi_ch1_int", 32'(ia.int_n),  32'h0);
    check_eq("nmi_ch1_vec", 32'(ia.vector), 32'h02);
    ack_a(1'b1); tick();
    check_eq("nmi_ch1_ack", 32'(ia.pending), 32'h0);
    ack_a(1'b0); tick();
    ia.irq_src = 2'b00; tick();
`else
    // Basic latency: pending one edge after the rise, int_n one edge later.
    ia.irq_src = 2'b00; tick();
    check_eq("low_no_pend", 32'(ia.pending), 32'h0);
    ia.irq_src = 2'b01; tick();
    check_eq("pend_lat", 32'(ia.pending), 32'h1);
    check_eq("int_lat1", 32'(ia.int_n),   32'h1);
    tick();
    check_eq("int_lat2", 32'(ia.int_n),  32'h0);
    check_eq("vec_ch0",  32'(ia.vector), 32'h00);
    check_eq("nmi_tied", 32'(ia.nmi_n),  32'h1);

    // Two pending channels served in priority order.
    ia.irq_src = 2'b11; tick();
    check_eq("pend_both", 32'(ia.pending), 32'h3);
    tick();
    ack_a(1'b1); tick();
    check_eq("ack1_clear", 32'(ia.pending), 32'h2);
    check_eq("ack1_vec",   32'(ia.vector),  32'h00);
    tick();
    check_eq("vec_frozen", 32'(ia.vector),  32'h00);
    check_eq("held_high",  32'(ia.pending), 32'h2);
    ack_a(1'b0); tick();
    check_eq("vec_ch1", 32'(ia.vector), 32'h02);
    ack_a(1'b1); tick();
    check_eq("ack2_clear", 32'(ia.pending), 32'h0);
    check_eq("ack2_vec",   32'(ia.vector),  32'h02);
    tick();
    check_eq("ack2_int",    32'(ia.int_n),  32'h1);
    check_eq("ack2_frozen", 32'(ia.vector), 32'h02);
    ack_a(1'b0); tick();
    check_eq("vec_idle", 32'(ia.vector), 32'h00);

    // Acknowledge with nothing pending.
    ack_a(1'b1); tick();
    check_eq("empty_ack_pend", 32'(ia.pending), 32'h0);
    check_eq("empty_ack_vec",  32'(ia.vector),  32'h00);
    ack_a(1'b0); tick();

    // Rise coinciding with the clear of the same channel.
    ia.irq_src = 2'b00; tick();
    ia.irq_src = 2'b01; tick();
    ia.irq_src = 2'b00; tick();
    ia.irq_src = 2'b01; ack_a(1'b1); tick();
    check_eq("set_wins", 32'(ia.pending), 32'h1);
    ack_a(1'b0); tick();
    ack_a(1'b1); tick();
    check_eq("clr_after", 32'(ia.pending), 32'h0);
    ack_a(1'b0); tick();

    // Mask load hides and then re-exposes a pending channel.
    ia.irq_src = 2'b11; tick();
    check_eq("pend_ch1", 32'(ia.pending), 32'h2);
    tick();
    check_eq("int_ch1", 32'(ia.int_n), 32'h0);
    ia.mask_we = 1'b1; ia.cpu_dout = 8'h00; tick();
    ia.mask_we = 1'b0; tick();
    check_eq("mask0_int",  32'(ia.int_n),   32'h1);
    check_eq("mask0_vec",  32'(ia.vector),  32'h00);
    check_eq("mask0_pend", 32'(ia.pending), 32'h2);
    ia.mask_we = 1'b1; ia.cpu_dout = 8'h02; tick();
    ia.mask_we = 1'b0;
    check_eq("unmask_int1", 32'(ia.int_n), 32'h1);
    tick();
    check_eq("unmask_int2", 32'(ia.int_n),   32'h0);
    check_eq("unmask_pend", 32'(ia.pending), 32'h2);
    check_eq("unmask_vec",  32'(ia.vector),  32'h02);
    ia.mask_we = 1'b1; ia.cpu_dout = 8'h03; tick();
    ia.mask_we = 1'b0;
    ack_a(1'b1); tick();
    ack_a(1'b0); tick();
    check_eq("mask_done", 32'(ia.pending), 32'h0);

    // Reset arriving in the middle of an acknowledge.
    ia.irq_src = 2'b00; tick();
    ia.irq_src = 2'b11; tick();
    tick();
    ack_a(1'b1); tick();
    check_eq("pre_rst_pend", 32'(ia.pending), 32'h2);
    rst = 1'b1; tick();
    check_eq("mid_rst_pend", 32'(ia.pending), 32'h0);
    check_eq("mid_rst_vec",  32'(ia.vector),  32'h00);
    check_eq("mid_rst_int",  32'(ia.int_n),   32'h1);
    rst = 1'b0; ack_a(1'b0); ia.irq_src = 2'b00; tick();
    ia.irq_src = 2'b10; tick();
    check_eq("post_rst_pend", 32'(ia.pending), 32'h2);
    tick();
    check_eq("post_rst_vec", 32'(ia.vector), 32'h02);
    check_eq("post_rst_int", 32'(ia.int_n),  32'h0);
    ack_a(1'b1); tick();
    ack_a(1'b0); tick();
    ia.irq_src = 2'b00; tick();
    check_eq("post_rst_clr", 32'(ia.pending), 32'h0);
`endif

    // dut_b: priority, VBASE offset, IORQ-only acknowledge, wide mask byte.
    ib.irq_src = 3'b110; tick();
    check_eq("b_pend", 32'(ib.pending), 32'h6);
    check_eq("b_int1", 32'(ib.int_n),   32'h1);
    tick();
    check_eq("b_vec_ch1", 32'(ib.vector), 32'h42);
    check_eq("b_int2",    32'(ib.int_n),  32'h0);
    ib.iorq_n = 1'b0; tick();
    check_eq("ackm1_0_clear", 32'(ib.pending), 32'h4);
    check_eq("b_ack_vec",     32'(ib.vector),  32'h42);
    ib.iorq_n = 1'b1; tick();
    check_eq("b_vec_ch2", 32'(ib.vector), 32'h44);
    ib.mask_we = 1'b1; ib.cpu_dout = 8'hFB; tick();
    ib.mask_we = 1'b0; tick();
    check_eq("b_mask_int",  32'(ib.int_n),   32'h1);
    check_eq("b_mask_pend", 32'(ib.pending), 32'h4);
    check_eq("b_mask_vec",  32'(ib.vector),  32'h40);

    // dut_a: IORQ without M1 is not an acknowledge when ACKM1=1.
    ia.irq_src = 2'b10; tick();
    check_eq("a_pend_ch1", 32'(ia.pending), 32'h2);
    ia.m1_n = 1'b1; ia.iorq_n = 1'b0; tick();
    tick();
    check_eq("ackm1_1_noclr", 32'(ia.pending), 32'h2);
    ia.iorq_n = 1'b1; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
